// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the RISC-V core execution controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_STEP = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } ctrl_state_t;

  // 20 ms of stable button level at 50 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  // 2 Hz free-run rate at 50 MHz.
  localparam int unsigned RUN_DIV_DEF         = 25000000;
  localparam int unsigned CNT_W_DEF           = 16;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw active-low button, filters contact bounce and emits a
// one-cycle press pulse when the settled level falls from released to pressed.
module button_debouncer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned    CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop synchronizer; idles at 1 (button released) out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the input disagrees with the settled level;
  // any agreement restarts the count, so bounces never reach the limit.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Execution controller for the single-cycle RISC-V core: drives a one-cycle
// clock enable for single-step, divided free-run and PC breakpoint halt.
module cpu_step_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RUN_DIV         = RUN_DIV_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_btn_n,
  input  logic              run_sw,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  output logic              cpu_en,
  output ctrl_state_t       state,
  output logic              halted,
  output logic [CNT_W-1:0]  step_count
);

  localparam int unsigned   DW       = cnt_width(RUN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  logic             btn_level, btn_press, press_ok;
  logic             run_s1_q, run_s2_q;
  ctrl_state_t      state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bp_hit, div_tc;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_btn (
    .clk   (clk),
    .reset (reset),
    .btn_n (step_btn_n),
    .level (btn_level),
    .press (btn_press)
  );

  // A press is only honoured while the settled level reads pressed.
  assign press_ok = btn_press & ~btn_level;

  assign bp_hit = bp_en && (pc == bp_addr);
  assign div_tc = (div_q == DIV_LAST);

  // Run switch is a level control and only needs metastability protection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      run_s1_q <= run_sw;
      run_s2_q <= run_s1_q;
    end
  end

  // Next state, divider and enable; the divider only advances in ST_RUN and
  // is cleared everywhere else so each run starts a full period.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    en_d    = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (run_s2_q) begin
          state_d = ST_RUN;
        end else if (press_ok) begin
          state_d = ST_STEP;
          en_d    = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = run_s2_q ? ST_RUN : ST_STOP;
      end
      ST_RUN: begin
        if (!run_s2_q) begin
          state_d = ST_STOP;
        end else if (div_tc) begin
          if (bp_hit) begin
            state_d = ST_HALT;
          end else begin
            en_d = 1'b1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_HALT: begin
        if (!run_s2_q) begin
          state_d = ST_STOP;
        end else if (press_ok) begin
          state_d = ST_STEP;
          en_d    = 1'b1;
        end
      end
      default: state_d = ST_STOP;
    endcase
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, en_d};
  end

  // Controller registers; the enable is registered so it is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOP;
      div_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_en     = en_q;
  assign state      = state_q;
  assign halted     = (state_q == ST_HALT);
  assign step_count = cnt_q;

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
Execution controller for the monocycle RISC-V core on the DE1-SoC. Runs the core from the 50 MHz board clock and issues a one-cycle clock-enable (cpu_en) to the PC and register/memory write paths; it replaces the button-as-clock scheme. Supports debounced single-step, free-run at a divided rate, and halt on a PC breakpoint, with status for LEDR/HEX.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before the debounced button level changes (20 ms at 50 MHz).
RUN_DIV, 25000000, clk cycles between cpu_en pulses in run mode (2 Hz); legal range >= 2.
CNT_W, 16, width of step_count.

Ports:
clk  in  1  50 MHz board clock (CLOCK_50), single clock domain.
reset  in  1  asynchronous, active-low reset (0 = reset).
step_btn_n  in  1  raw step button (KEY[0]), active-low, asynchronous.
run_sw  in  1  raw run switch (SW[0]), 1 = run, asynchronous.
bp_en  in  1  breakpoint enable (SW[2]); static during operation.
bp_addr  in  32  breakpoint PC value.
pc  in  32  current PC from the program counter.
cpu_en  out  1  registered one-cycle enable; the core advances exactly one instruction per high cycle.
state  out  2  current FSM state (ctrl_state_t).
halted  out  1  1 while in ST_HALT.
step_count  out  CNT_W  count of cpu_en pulses issued.

Behaviour:
- Reset (reset=0, asynchronous): state=ST_STOP, cpu_en=0, halted=0, step_count=0, divider=0, synchronizers=1 (button released) and 0 (run), debounced level=1.
- Input sync: two-flop synchronizer on step_btn_n and run_sw. run_sw is not debounced.
- Debounce: counter restarts whenever the synchronized input differs from the debounced level; the level updates when the input has differed for DEBOUNCE_CYCLES consecutive cycles. press = one-cycle pulse on a debounced 1->0 transition. Release generates nothing.
- Latency: press is asserted in cycle N; cpu_en is high in cycle N+1 only. Holding the button yields exactly one step.
- ST_STOP: cpu_en=0, divider held at 0.
  - run_sync=1 -> ST_RUN. This takes priority: a press in the same cycle is discarded.
  - Otherwise press -> ST_STEP.
  - Breakpoints are ignored in this state.
- ST_STEP: cpu_en=1 for this one cycle, step_count+1. Next state is ST_RUN if run_sync=1, else ST_STOP.
- ST_RUN: divider counts 0..RUN_DIV-1, then wraps.
  - At divider==RUN_DIV-1 with bp_en=1 and pc==bp_addr: go to ST_HALT, no pulse.
  - At terminal count with no match: cpu_en=1 for one cycle, step_count+1.
  - run_sync=0 -> ST_STOP with divider cleared; this overrides a terminal count in the same cycle (no pulse).
  - Presses are ignored.
- ST_HALT: cpu_en=0, halted=1, divider=0.
  - press -> ST_STEP. This executes the breakpoint instruction, so pc moves off bp_addr before the next compare.
  - run_sync=0 -> ST_STOP, with priority over a press in the same cycle.
- step_count wraps from all-ones to 0 without flagging.
- cpu_en is never high on two consecutive cycles.
- Reset mid-run: everything returns to reset values immediately and any pending pulse is dropped.

Decomposition:
- Package cpu_ctrl_pkg:
  - typedef enum logic [1:0] ctrl_state_t: ST_STOP=2'b00, ST_STEP=2'b01, ST_RUN=2'b10, ST_HALT=2'b11.
  - Default constants DEBOUNCE_CYCLES_DEF and RUN_DIV_DEF.
- One sub-module, button_debouncer: synchronizer, debounce counter, press pulse. Parameter DEBOUNCE_CYCLES; ports clk, reset, btn_n, level, press.
- The top contains the FSM, divider, breakpoint compare and counter.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, RUN_DIV=3):
- Single step: hold step_btn_n=0 for 20 cycles, then release -> exactly one cpu_en pulse, step_count=1, state returns to 00.
- Bounce rejection: toggle step_btn_n every 2 cycles for 16 cycles, then hold it high -> no cpu_en pulse, step_count=0.
- Run: run_sw=1, bp_en=0 for 30 cycles -> cpu_en pulses exactly 3 cycles apart, never consecutive; run_sw=0 -> state=00 and pulses stop.
- Breakpoint: bp_en=1, bp_addr=32'h0000000C, pc model advancing +4 per cpu_en from 0 -> 3 pulses, then state=11, halted=1, pc=0x0C; one press -> one pulse, pc=0x10, run resumes.
- Priority: in ST_STOP, run_sw rises in the same cycle a press is detected -> state 10 and no ST_STEP pulse; a terminal count coinciding with run_sync=0 -> no pulse.
- Reset mid-run: assert reset=0 asynchronously between clock edges -> cpu_en=0, step_count=0, state=00 immediately; set step_count to 16'hFFFF, one step -> 0.
